connect_fifo2: RTL

CONNECT_FIFO2 -- requirements
Module: connect_fifo2

---
 rtl/connect_fifo2_if.sv | 28 ++
 rtl/connect_fifo2.sv | 76 +++++++
 2 files changed

// File: rtl/connect_fifo2_if.sv
// Handshake and data bundle for the connect_fifo2 receive buffer.
// The writer/reader side drives through "master"; the FIFO sits on "slave".
interface connect_fifo2_if #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
);
    localparam int CNTW = $clog2(DEPTH) + 1;

    logic             enq__ENA;
    logic             enq__RDY;
    logic [WIDTH-1:0] enq_v1;
    logic [WIDTH-1:0] enq_v2;
    logic             deq__ENA;
    logic             deq__RDY;
    logic [WIDTH-1:0] first_v1;
    logic [WIDTH-1:0] first_v2;
    logic [CNTW-1:0]  count;

    modport slave (
        input  enq__ENA, enq_v1, enq_v2, deq__ENA,
        output enq__RDY, deq__RDY, first_v1, first_v2, count
    );

    modport master (
        output enq__ENA, enq_v1, enq_v2, deq__ENA,
        input  enq__RDY, deq__RDY, first_v1, first_v2, count
    );
endinterface

// File: rtl/connect_fifo2.sv
// Registered receiving end of a two-lane connection: a DEPTH-entry FIFO of
// (v1, v2) pairs with ready flags derived only from the registered count.
module connect_fifo2 #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input logic             CLK,
    input logic             nRST,
    connect_fifo2_if.slave  io
);
    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = PTRW + 1;
    localparam logic [CNTW-1:0] FULL_COUNT = CNTW'(DEPTH);

    typedef logic [2*WIDTH-1:0] entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            enq_fire;
    logic            deq_fire;
    entry_t          head;

    // Ready flags depend on registered state only, so no ENA-to-RDY path exists.
    assign io.enq__RDY = (count_q != FULL_COUNT);
    assign io.deq__RDY = (count_q != '0);
    assign io.count    = count_q;

    assign enq_fire = io.enq__ENA && io.enq__RDY;
    assign deq_fire = io.deq__ENA && io.deq__RDY;

    // Stale entries behind the read pointer are masked so an empty FIFO shows zero.
    assign head        = mem_q[rd_ptr_q];
    assign io.first_v1 = io.deq__RDY ? head[2*WIDTH-1:WIDTH] : '0;
    assign io.first_v2 = io.deq__RDY ? head[WIDTH-1:0]       : '0;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (enq_fire) begin
            mem_d[wr_ptr_q] = {io.enq_v1, io.enq_v2};
            wr_ptr_d        = wr_ptr_q + PTRW'(1);
        end

        if (deq_fire) begin
            rd_ptr_d = rd_ptr_q + PTRW'(1);
        end

        case ({enq_fire, deq_fire})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule
